// File: rtl/pump_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pump_dispense_ctrl
// Brief    : Fuel dispensing controller: pump/valve drive, flow count, cost.
// Revision : 1.0
// ============================================================================
module pump_dispense_ctrl #(
  parameter int unsigned ML_PER_PULSE = 10,
  parameter int unsigned SLOW_ML      = 200,
  parameter int unsigned TIMEOUT_CYC  = 50000000,
  parameter int unsigned DONE_HOLD    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] target_ml,
  input  logic [23:0] target_cost,
  input  logic [15:0] unit_price,
  input  logic        nozzle_out,
  input  logic        stop_btn,
  input  logic        flow_in,
  output logic        pump_en,
  output logic        valve_open,
  output logic        pump_slow,
  output logic [23:0] dispensed_ml,
  output logic [23:0] dispensed_cost,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [2:0]  state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_PUMP  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(DONE_HOLD + 1);
  localparam logic [23:0] C_SAT  = 24'hFFFFFF;

  logic [2:0]        state_q, state_d;
  logic [1:0]        nozzle_sync_q, nozzle_sync_d;
  logic [2:0]        flow_sync_q, flow_sync_d;
  logic [23:0]       target_ml_q, target_ml_d;
  logic [23:0]       target_cost_q, target_cost_d;
  logic [15:0]       unit_price_q, unit_price_d;
  logic [23:0]       disp_ml_q, disp_ml_d;
  logic [23:0]       disp_cost_q, disp_cost_d;
  logic [39:0]       acc_q, acc_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic        w_nozzle;
  logic        w_pulse;
  logic        w_start_ok;
  logic [24:0] w_ml_sum;
  logic [23:0] w_ml_inc;
  logic [40:0] w_acc_sum;
  logic [39:0] w_acc_inc;
  logic [39:0] w_cost_full;
  logic [23:0] w_cost_inc;
  logic        w_reached;
  logic [23:0] w_remaining;

  assign w_nozzle   = nozzle_sync_q[1];
  assign w_pulse    = flow_sync_q[1] & ~flow_sync_q[2];
  assign w_start_ok = start && (target_ml != 24'd0);

  // Both running totals saturate instead of wrapping.
  assign w_ml_sum    = {1'b0, disp_ml_q} + 25'(ML_PER_PULSE);
  assign w_ml_inc    = w_ml_sum[24] ? C_SAT : w_ml_sum[23:0];
  assign w_acc_sum   = {1'b0, acc_q} + 41'(unit_price_q) * 41'(ML_PER_PULSE);
  assign w_acc_inc   = w_acc_sum[40] ? {40{1'b1}} : w_acc_sum[39:0];
  assign w_cost_full = w_acc_inc / 40'd1000;
  assign w_cost_inc  = (w_cost_full > 40'(C_SAT)) ? C_SAT : w_cost_full[23:0];
  assign w_reached   = w_pulse && (w_ml_inc >= target_ml_q);
  assign w_remaining = (target_ml_q > disp_ml_q) ? (target_ml_q - disp_ml_q) : 24'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_start_ok) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (stop_btn)      state_d = S_IDLE;
        else if (w_nozzle) state_d = S_PUMP;
      end
      S_PUMP: begin
        if (stop_btn || !w_nozzle) state_d = S_DONE;
        else if (w_reached)        state_d = S_DONE;
        else if (!w_pulse && (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)))
          state_d = S_FAULT;
      end
      S_DONE: begin
        if (hold_cnt_q == HOLD_W'(DONE_HOLD - 1)) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (start && !w_nozzle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_ARMED) || (state_q == S_PUMP);
    done       = (state_q == S_DONE);
    fault      = (state_q == S_FAULT);
    pump_en    = (state_q == S_PUMP);
    valve_open = (state_q == S_PUMP);
    pump_slow  = (state_q == S_PUMP) && (w_remaining < 24'(SLOW_ML));
    state_o    = state_q;
    dispensed_ml   = disp_ml_q;
    dispensed_cost = disp_cost_q;
  end

  always_comb begin
    nozzle_sync_d = {nozzle_sync_q[0], nozzle_out};
    flow_sync_d   = {flow_sync_q[1:0], flow_in};
    target_ml_d   = target_ml_q;
    target_cost_d = target_cost_q;
    unit_price_d  = unit_price_q;
    disp_ml_d     = disp_ml_q;
    disp_cost_d   = disp_cost_q;
    acc_d         = acc_q;
    idle_cnt_d    = '0;
    hold_cnt_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (w_start_ok) begin
          target_ml_d   = target_ml;
          target_cost_d = target_cost;
          unit_price_d  = unit_price;
          disp_ml_d     = 24'd0;
          disp_cost_d   = 24'd0;
          acc_d         = 40'd0;
        end
      end
      S_PUMP: begin
        if (w_pulse) begin
          disp_ml_d = w_ml_inc;
          acc_d     = w_acc_inc;
          // A full fill reports the prepaid amount, not the truncated running cost.
          disp_cost_d = (w_reached && !stop_btn && w_nozzle) ? target_cost_q : w_cost_inc;
        end else begin
          idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
      end
      S_DONE: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      nozzle_sync_q <= '0;
      flow_sync_q   <= '0;
      target_ml_q   <= '0;
      target_cost_q <= '0;
      unit_price_q  <= '0;
      disp_ml_q     <= '0;
      disp_cost_q   <= '0;
      acc_q         <= '0;
      idle_cnt_q    <= '0;
      hold_cnt_q    <= '0;
    end else begin
      nozzle_sync_q <= nozzle_sync_d;
      flow_sync_q   <= flow_sync_d;
      target_ml_q   <= target_ml_d;
      target_cost_q <= target_cost_d;
      unit_price_q  <= unit_price_d;
      disp_ml_q     <= disp_ml_d;
      disp_cost_q   <= disp_cost_d;
      acc_q         <= acc_d;
      idle_cnt_q    <= idle_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

endmodule
`default_nettype wire
